// File: rtl/shoe_pkg.sv
// rtl/shoe_pkg.sv - shared types and constants for the baccarat shoe controller
package shoe_pkg;

    localparam int NUM_RANKS = 13;

    localparam logic [3:0] CARD_ACE   = 4'd1;
    localparam logic [3:0] CARD_TWO   = 4'd2;
    localparam logic [3:0] CARD_THREE = 4'd3;
    localparam logic [3:0] CARD_FOUR  = 4'd4;
    localparam logic [3:0] CARD_FIVE  = 4'd5;
    localparam logic [3:0] CARD_SIX   = 4'd6;
    localparam logic [3:0] CARD_SEVEN = 4'd7;
    localparam logic [3:0] CARD_EIGHT = 4'd8;
    localparam logic [3:0] CARD_NINE  = 4'd9;
    localparam logic [3:0] CARD_TEN   = 4'd10;
    localparam logic [3:0] CARD_JACK  = 4'd11;
    localparam logic [3:0] CARD_QUEEN = 4'd12;
    localparam logic [3:0] CARD_KING  = 4'd13;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int LOAD_PCARD1 = 5;
    localparam int LOAD_DCARD1 = 4;
    localparam int LOAD_PCARD2 = 3;
    localparam int LOAD_DCARD2 = 2;
    localparam int LOAD_PCARD3 = 1;
    localparam int LOAD_DCARD3 = 0;

    typedef enum logic [1:0] {
        ST_FILL      = 2'd0,
        ST_READY     = 2'd1,
        ST_EXHAUSTED = 2'd2,
        ST_BURN      = 2'd3
    } shoe_state_e;

    function automatic logic [7:0] lfsr_step(input logic [7:0] value);
        return {1'b0, value[7:1]} ^ (value[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/shoe_rank_picker.sv
// rtl/shoe_rank_picker.sv - first non-empty rank at or after start, wrapping King to Ace
module shoe_rank_picker
    import shoe_pkg::*;
(
    input  logic [3:0]           start_rank,
    input  logic [NUM_RANKS-1:0] nonzero,
    output logic [3:0]           rank,
    output logic                 found
);

    logic [4:0] start_idx;
    logic [4:0] idx;

    always_comb begin
        rank      = 4'd0;
        found     = 1'b0;
        idx       = 5'd0;
        start_idx = {1'b0, start_rank - CARD_ACE};
        for (int i = 0; i < NUM_RANKS; i++) begin
            idx = start_idx + 5'(i);
            if (idx >= 5'(NUM_RANKS)) begin
                idx = idx - 5'(NUM_RANKS);
            end
            if (!found && nonzero[idx[3:0]]) begin
                found = 1'b1;
                rank  = idx[3:0] + CARD_ACE;
            end
        end
    end

endmodule

// File: rtl/shoe_controller.sv
// rtl/shoe_controller.sv - finite baccarat shoe with cut-card reshuffle; SHOE_BURN_CARD_EN adds a burn state
module shoe_controller
    import shoe_pkg::*;
#(
    parameter int         NUM_DECKS = 1,
    parameter int         CUT_LEFT  = 15,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [5:0] load_req,
    input  logic       round_start,
    output logic [3:0] next_card,
    output logic       card_valid,
    output logic [8:0] cards_remaining,
    output logic       shoe_low,
    output logic       reshuffle_busy,
    output logic       load_err
);

    localparam logic [5:0] FULL_RANK = 6'(4 * NUM_DECKS);
    localparam logic [8:0] FULL_SHOE = 9'(52 * NUM_DECKS);
    localparam logic [8:0] CUT_LEVEL = 9'(CUT_LEFT);
    localparam logic [7:0] SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    shoe_state_e state;
    logic [7:0]  lfsr;
    logic [5:0]  counts      [NUM_RANKS];
    logic [5:0]  counts_post [NUM_RANKS];
    logic [8:0]  rem_post;
    logic [NUM_RANKS-1:0] nonzero;
    logic        take;
    logic [3:0]  take_idx;
    logic        multi_hot;
    logic        bad_load;
    logic [3:0]  start_rank;
    logic [3:0]  pick_rank;
    logic        pick_found;
    logic [3:0]  pick_card;

    assign multi_hot  = |(load_req & (load_req - 6'd1));
    assign bad_load   = (|load_req) && ((state != ST_READY) || multi_hot);
    assign take_idx   = next_card - CARD_ACE;
    assign start_rank = 4'(lfsr % 8'd13) + CARD_ACE;
    assign pick_card  = pick_found ? pick_rank : 4'd0;

    // Counts as they will stand after this edge; the pick must see them, not the old ones
    always_comb begin
        take     = 1'b0;
        rem_post = cards_remaining;
        nonzero  = '0;
        for (int i = 0; i < NUM_RANKS; i++) begin
            counts_post[i] = counts[i];
        end
        case (state)
            ST_FILL: begin
                for (int i = 0; i < NUM_RANKS; i++) begin
                    counts_post[i] = FULL_RANK;
                end
                rem_post = FULL_SHOE;
            end
            ST_READY: take = |load_req;
            ST_BURN:  take = 1'b1;
            default:  take = 1'b0;
        endcase
        if (take) begin
            rem_post = cards_remaining - 9'd1;
            for (int i = 0; i < NUM_RANKS; i++) begin
                if (4'(i) == take_idx) begin
                    counts_post[i] = counts[i] - 6'd1;
                end
            end
        end
        for (int i = 0; i < NUM_RANKS; i++) begin
            nonzero[i] = (counts_post[i] != 6'd0);
        end
    end

    shoe_rank_picker u_picker (
        .start_rank (start_rank),
        .nonzero    (nonzero),
        .rank       (pick_rank),
        .found      (pick_found)
    );

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state           <= ST_FILL;
            lfsr            <= SEED_EFF;
            cards_remaining <= 9'd0;
            next_card       <= 4'd0;
            card_valid      <= 1'b0;
            shoe_low        <= 1'b0;
            reshuffle_busy  <= 1'b1;
            load_err        <= 1'b0;
            for (int i = 0; i < NUM_RANKS; i++) begin
                counts[i] <= 6'd0;
            end
        end else begin
            lfsr            <= lfsr_step(lfsr);
            cards_remaining <= rem_post;
            shoe_low        <= (rem_post <= CUT_LEVEL);
            for (int i = 0; i < NUM_RANKS; i++) begin
                counts[i] <= counts_post[i];
            end
            if (bad_load) begin
                load_err <= 1'b1;
            end
            case (state)
                ST_FILL: begin
                    next_card <= pick_card;
`ifdef SHOE_BURN_CARD_EN
                    card_valid     <= 1'b0;
                    reshuffle_busy <= 1'b1;
                    state          <= ST_BURN;
`else
                    card_valid     <= 1'b1;
                    reshuffle_busy <= 1'b0;
                    state          <= ST_READY;
`endif
                end
`ifdef SHOE_BURN_CARD_EN
                ST_BURN: begin
                    next_card      <= pick_card;
                    card_valid     <= 1'b1;
                    reshuffle_busy <= 1'b0;
                    state          <= ST_READY;
                end
`endif
                ST_READY: begin
                    if (take) begin
                        next_card <= pick_card;
                    end
                    // A same-cycle load is already reflected in rem_post for the cut compare
                    if (round_start && (rem_post <= CUT_LEVEL)) begin
                        card_valid     <= 1'b0;
                        reshuffle_busy <= 1'b1;
                        state          <= ST_FILL;
                    end else if (rem_post == 9'd0) begin
                        card_valid <= 1'b0;
                        state      <= ST_EXHAUSTED;
                    end
                end
                ST_EXHAUSTED: begin
                    card_valid <= 1'b0;
                    if (round_start) begin
                        reshuffle_busy <= 1'b1;
                        state          <= ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule
